// File: rtl/audio_output_pkg.sv
// rtl/audio_output_pkg.sv - shared conversion-mode type for the audio output stage
//
// Purpose: conversion-mode encoding used by audio_sample_output and its bench.
// Ports:   none (package).
package audio_output_pkg;

  // Conversion applied to each sample as it leaves the buffer.
  typedef enum logic [1:0] {
    MODE_TRUNC = 2'd0,  // keep the low OUT_WIDTH bits (wraps on overflow)
    MODE_SAT   = 2'd1,  // clamp to all ones when the value does not fit
    MODE_SCALE = 2'd2,  // keep the top OUT_WIDTH bits (MSB-aligned)
    MODE_MUTE  = 2'd3   // emit zero, sample is still consumed
  } audio_mode_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - small synchronous sample FIFO with occupancy output
//
// Purpose: buffers APU samples between the input handshake and the output tick.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   push, push_data    write request and data (ignored while full)
//   pop                read request (ignored while empty)
//   head               oldest entry, valid whenever empty is low
//   full, empty        occupancy flags
//   level              number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module audio_sample_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Storage has no reset: stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_sample_output.sv
// rtl/audio_sample_output.sv - rate-paced audio output stage with width conversion
//
// Purpose: accepts APU mix samples over valid/ready, buffers them, and emits one
// converted sample per output tick. An empty buffer on a tick holds the previous
// sample and flags an underrun.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_mode              conversion mode (audio_mode_t encoding)
//   i_sample, i_valid   incoming sample and its valid
//   o_ready             buffer can accept (depends on occupancy only)
//   o_sample            current output sample
//   o_tick              one-cycle pulse aligned with each o_sample update slot
//   o_underrun          one-cycle pulse, a tick found the buffer empty
//   o_level             buffer occupancy
//   o_underrun_count    saturating underrun count
// Build option: AUDIO_SAMPLE_OUTPUT_STATS_EN enables o_underrun_count; when it
// is not defined the counter is absent and the port reads 0.
module audio_sample_output
  import audio_output_pkg::*;
#(
  parameter int IN_WIDTH   = 9,
  parameter int OUT_WIDTH  = 8,
  parameter int TICK_DIV   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [1:0]                    i_mode,
  input  logic [IN_WIDTH-1:0]           i_sample,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [OUT_WIDTH-1:0]          o_sample,
  output logic                          o_tick,
  output logic                          o_underrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic [15:0]                   o_underrun_count
);

  // A one-clock divider still needs a 1-bit counter to keep widths legal.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]        tick_cnt;
  logic                 tick;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [IN_WIDTH-1:0]  fifo_head;
  logic                 push;
  logic                 pop;
  audio_mode_t          mode;
  logic [OUT_WIDTH-1:0] converted;

  // Output-rate divider: tick on the last count of each period.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Ready comes only from occupancy, so a full buffer rejects a push even on a
  // tick cycle that frees a slot; the slot is offered on the following cycle.
  assign o_ready = !fifo_full;
  assign push    = i_valid && !fifo_full;
  assign pop     = tick && !fifo_empty;

  audio_sample_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_reset),
    .push      (push),
    .push_data (i_sample),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (o_level)
  );

  // Mode is taken in the pop cycle, so a change applies to the next sample out.
  assign mode = audio_mode_t'(i_mode);

  always_comb begin
    converted = '0;
    case (mode)
      MODE_TRUNC: converted = fifo_head[OUT_WIDTH-1:0];
      MODE_SAT: begin
        // Any bit above the output range means the value does not fit.
        if ((fifo_head >> OUT_WIDTH) != '0) begin
          converted = '1;
        end else begin
          converted = fifo_head[OUT_WIDTH-1:0];
        end
      end
      MODE_SCALE: converted = fifo_head[IN_WIDTH-1 -: OUT_WIDTH];
      MODE_MUTE:  converted = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_sample   <= '0;
      o_tick     <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_tick     <= tick;
      o_underrun <= tick && fifo_empty;
      if (pop) begin
        o_sample <= converted;
      end
    end
  end

`ifdef AUDIO_SAMPLE_OUTPUT_STATS_EN
  logic [15:0] underrun_count;

  // Advances on the same edge that raises o_underrun, so the two stay aligned.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      underrun_count <= '0;
    end else if (tick && fifo_empty && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end

  assign o_underrun_count = underrun_count;
`else
  assign o_underrun_count = '0;
`endif

endmodule
